// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - sequential single-precision floating-point accumulator
//
// Sums N_TERMS IEEE-754 single products using an ACCEPT/ALIGN/ADD/NORM/DONE FSM.
// Arithmetic truncates, flushes denormals to zero, saturates overflow to infinity.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    product input handshake (in_ready high only in ACCEPT)
//   in_data[31:0]        product {sign, exp, frac}
//   out_valid/out_ready  sum output handshake (out_valid high only in DONE)
//   out_data[31:0]       registered accumulated sum
//   busy                 high while in ALIGN, ADD or NORM

module fp_accumulator #(
  parameter int N_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int CW = $clog2(N_TERMS + 1);

  typedef enum logic [2:0] {S_ACCEPT, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          acc_sign_q, acc_sign_d;
  logic [7:0]    acc_exp_q, acc_exp_d;
  logic [23:0]   acc_mant_q, acc_mant_d;
  logic [31:0]   op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Working result: X after ALIGN, sum after ADD, normalised in NORM.
  logic          res_sign_q, res_sign_d;
  logic [7:0]    res_exp_q, res_exp_d;
  logic [23:0]   res_mant_q, res_mant_d;
  logic [23:0]   y_mant_q, y_mant_d;
  logic          sub_q, sub_d;
  logic          special_q, special_d;  // infinity result, NORM completes at once
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [31:0]   out_data_q, out_data_d;

  // Operand decode: exp == 0 is zero regardless of fraction.
  logic          op_sign;
  logic [7:0]    op_exp;
  logic [23:0]   op_mant;
  logic          acc_ge;
  logic [7:0]    x_exp, y_exp, shamt;
  logic [23:0]   y_mant_raw;
  logic [24:0]   sum;
  logic [7:0]    exp_inc;
  logic          fin;
  logic          fin_sign;
  logic [7:0]    fin_exp;
  logic [23:0]   fin_mant;

  assign op_sign = op_q[31];
  assign op_exp  = op_q[30:23];
  assign op_mant = (op_exp == 8'd0) ? 24'd0 : {1'b1, op_q[22:0]};
  assign acc_ge  = {acc_exp_q, acc_mant_q} >= {op_exp, op_mant};
  assign x_exp   = acc_ge ? acc_exp_q : op_exp;
  assign y_exp   = acc_ge ? op_exp : acc_exp_q;
  assign y_mant_raw = acc_ge ? op_mant : acc_mant_q;
  assign shamt   = x_exp - y_exp;
  // X >= Y by construction, so the subtraction never borrows.
  assign sum     = sub_q ? ({1'b0, res_mant_q} - {1'b0, y_mant_q})
                         : ({1'b0, res_mant_q} + {1'b0, y_mant_q});
  assign exp_inc = res_exp_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    acc_sign_d  = acc_sign_q;
    acc_exp_d   = acc_exp_q;
    acc_mant_d  = acc_mant_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    res_sign_d  = res_sign_q;
    res_exp_d   = res_exp_q;
    res_mant_d  = res_mant_q;
    y_mant_d    = y_mant_q;
    sub_d       = sub_q;
    special_d   = special_q;
    out_data_d  = out_data_q;
    fin         = 1'b0;
    fin_sign    = res_sign_q;
    fin_exp     = res_exp_q;
    fin_mant    = res_mant_q;

    case (state_q)
      S_ACCEPT: begin
        if (in_valid) begin
          op_d    = in_data;
          cnt_d   = cnt_q + CW'(1);
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (acc_exp_q == 8'hFF || op_exp == 8'hFF) begin
          // Accumulator sign wins when both are infinite.
          special_d  = 1'b1;
          res_sign_d = (acc_exp_q == 8'hFF) ? acc_sign_q : op_sign;
          res_exp_d  = 8'hFF;
          res_mant_d = 24'd0;
        end else begin
          special_d  = 1'b0;
          res_sign_d = acc_ge ? acc_sign_q : op_sign;
          res_exp_d  = x_exp;
          res_mant_d = acc_ge ? acc_mant_q : op_mant;
          y_mant_d   = (shamt >= 8'd25) ? 24'd0 : (y_mant_raw >> shamt);
          sub_d      = acc_sign_q ^ op_sign;
        end
        state_d = S_ADD;
      end
      S_ADD: begin
        if (!special_q) begin
          if (sum[24]) begin
            if (exp_inc == 8'hFF) begin
              special_d  = 1'b1;
              res_exp_d  = 8'hFF;
              res_mant_d = 24'd0;
            end else begin
              res_exp_d  = exp_inc;
              res_mant_d = sum[24:1];
            end
          end else begin
            res_mant_d = sum[23:0];
          end
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (special_q) begin
          fin      = 1'b1;
          fin_mant = 24'd0;
        end else if (res_mant_q == 24'd0 || (!res_mant_q[23] && res_exp_q == 8'd1)) begin
          // Exact cancellation or underflow: result is +0.
          fin      = 1'b1;
          fin_sign = 1'b0;
          fin_exp  = 8'd0;
          fin_mant = 24'd0;
        end else if (res_mant_q[23]) begin
          fin = 1'b1;
        end else begin
          res_mant_d = {res_mant_q[22:0], 1'b0};
          res_exp_d  = res_exp_q - 8'd1;
        end
        if (fin) begin
          acc_sign_d = fin_sign;
          acc_exp_d  = fin_exp;
          acc_mant_d = fin_mant;
          if (cnt_q == CW'(N_TERMS)) begin
            out_data_d = {fin_sign, fin_exp, fin_mant[22:0]};
            state_d    = S_DONE;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          acc_sign_d = 1'b0;
          acc_exp_d  = 8'd0;
          acc_mant_d = 24'd0;
          cnt_d      = '0;
          state_d    = S_ACCEPT;
        end
      end
      default: state_d = S_ACCEPT;
    endcase

    in_ready_d  = (state_d == S_ACCEPT);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_ALIGN) || (state_d == S_ADD) || (state_d == S_NORM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACCEPT;
      acc_sign_q  <= 1'b0;
      acc_exp_q   <= 8'd0;
      acc_mant_q  <= 24'd0;
      op_q        <= 32'd0;
      cnt_q       <= '0;
      res_sign_q  <= 1'b0;
      res_exp_q   <= 8'd0;
      res_mant_q  <= 24'd0;
      y_mant_q    <= 24'd0;
      sub_q       <= 1'b0;
      special_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      acc_sign_q  <= acc_sign_d;
      acc_exp_q   <= acc_exp_d;
      acc_mant_q  <= acc_mant_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      res_sign_q  <= res_sign_d;
      res_exp_q   <= res_exp_d;
      res_mant_q  <= res_mant_d;
      y_mant_q    <= y_mant_d;
      sub_q       <= sub_d;
      special_q   <= special_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// tb/tb_fp_accumulator.sv - scoreboard bench for fp_accumulator (N_TERMS=4 and 2)

module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b0;  // 0: four-term instance, 1: two-term instance
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        out_ready = 1'b1;

  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_data4;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] out_data2;

  logic        obs_in_ready, obs_out_valid, obs_busy;
  logic [31:0] obs_out_data;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  fp_accumulator #(.N_TERMS(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && !sel),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .busy      (busy4)
  );

  fp_accumulator #(.N_TERMS(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && sel),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .busy      (busy2)
  );

  assign obs_in_ready  = sel ? in_ready2  : in_ready4;
  assign obs_out_valid = sel ? out_valid2 : out_valid4;
  assign obs_busy      = sel ? busy2      : busy4;
  assign obs_out_data  = sel ? out_data2  : out_data4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one term; measure cycles from handshake until in_ready (or out_valid
  // for the last term of a group) and require busy throughout.
  task automatic send(input logic [31:0] d, input int lat, input bit last);
    int n;
    int nb;
    n = 0;
    while (!obs_in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'd0, obs_in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    n  = 1;
    nb = 0;
    while (!(last ? obs_out_valid : obs_in_ready) && n < 300) begin
      if (!obs_busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    check(last ? "out_latency" : "in_latency", n, lat);
    check("busy_gap", nb, 0);
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && obs_out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("out_data", obs_out_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready4", {31'd0, in_ready4}, 32'd1);
    check("rst_out_valid4", {31'd0, out_valid4}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_out_data4", out_data4, 32'd0);
    check("rst_in_ready2", {31'd0, in_ready2}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal sum: 4 x 1.0
    sel = 1'b0;
    sb.push_back(32'h40800000);
    repeat (3) send(32'h3F800000, 4, 1'b0);
    send(32'h3F800000, 4, 1'b1);
    @(posedge clk); #1;
    check("ready_after_out", {31'd0, obs_in_ready}, 32'd1);
    check("valid_after_out", {31'd0, obs_out_valid}, 32'd0);

    // Cancellation then zero input
    sb.push_back(32'h40000000);
    send(32'h3FC00000, 4, 1'b0);
    send(32'hBFC00000, 4, 1'b0);
    send(32'h40000000, 4, 1'b0);
    send(32'h00000000, 4, 1'b1);
    @(posedge clk); #1;

    // Deep normalisation in the middle of a four-term group
    sb.push_back(32'h34000000);
    send(32'h3F800000, 4, 1'b0);
    send(32'hBF7FFFFF, 27, 1'b0);
    send(32'h00000000, 4, 1'b0);
    send(32'h00000000, 4, 1'b1);
    @(posedge clk); #1;

    // Two-term instance
    sel = 1'b1;
    sb.push_back(32'h34000000);
    send(32'h3F800000, 4, 1'b0);
    send(32'hBF7FFFFF, 27, 1'b1);
    @(posedge clk); #1;
    sb.push_back(32'h7F800000);
    send(32'h7F7FFFFF, 4, 1'b0);
    send(32'h7F7FFFFF, 4, 1'b1);
    @(posedge clk); #1;
    sb.push_back(32'hFF800000);
    send(32'hFF800000, 4, 1'b0);
    send(32'h3F800000, 4, 1'b1);
    @(posedge clk); #1;
    sb.push_back(32'h7F800000);
    send(32'h7F800000, 4, 1'b0);
    send(32'hFF800000, 4, 1'b1);
    @(posedge clk); #1;

    // Back-pressure
    sel = 1'b0;
    out_ready = 1'b0;
    sb.push_back(32'h40800000);
    repeat (3) send(32'h3F800000, 4, 1'b0);
    send(32'h3F800000, 4, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      check("bp_out_valid", {31'd0, obs_out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, obs_in_ready}, 32'd0);
      check("bp_out_data", obs_out_data, 32'h40800000);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after", {31'd0, obs_in_ready}, 32'd1);
    sb.push_back(32'h41000000);
    repeat (3) send(32'h40000000, 4, 1'b0);
    send(32'h40000000, 4, 1'b1);
    @(posedge clk); #1;

    // Reset during NORM of term 3 (group discarded, nothing pushed)
    send(32'h3F800000, 4, 1'b0);
    send(32'h3F800000, 4, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("norm_busy", {31'd0, obs_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, obs_in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, obs_out_valid}, 32'd0);
    check("arst_busy", {31'd0, obs_busy}, 32'd0);
    check("arst_out_data", obs_out_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back(32'h40800000);
    repeat (3) send(32'h3F800000, 4, 1'b0);
    send(32'h3F800000, 4, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
